// File: rtl/memory_copy_engine.sv
// rtl/memory_copy_engine.sv - block copy/fill initiator on one port of the dual-port memory
// Outputs are registered for the state being entered, so each access is on the bus for the whole cycle.
module memory_copy_engine #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic                  fill_mode,
    input  logic [ADDR_WIDTH-1:0] src_addr,
    input  logic [ADDR_WIDTH-1:0] dst_addr,
    input  logic [ADDR_WIDTH-1:0] length,
    input  logic [DATA_WIDTH-1:0] fill_value,
    input  logic                  abort,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_write_data,
    output logic                  mem_write_enable,
    input  logic [DATA_WIDTH-1:0] mem_read_data
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WRITE,
        S_FILL,
        S_DONE
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] src_q, src_d;
    logic [ADDR_WIDTH-1:0] dst_q, dst_d;
    logic [ADDR_WIDTH-1:0] count_q, count_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  we_q, we_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        count_d = count_q;
        data_d  = '0;
        addr_d  = '0;
        we_d    = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;

        case (state_q)
            // DONE returns to IDLE on the same edge a new request can be taken.
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (start) begin
                    src_d   = src_addr;
                    dst_d   = dst_addr;
                    count_d = length;
                    if (length == '0) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else if (fill_mode) begin
                        state_d = S_FILL;
                        busy_d  = 1'b1;
                        addr_d  = dst_addr;
                        data_d  = fill_value;
                        we_d    = 1'b1;
                    end else begin
                        state_d = S_READ;
                        busy_d  = 1'b1;
                        addr_d  = src_addr;
                    end
                end
            end
            S_READ: begin
                state_d = S_WRITE;
                busy_d  = 1'b1;
                addr_d  = dst_q;
                data_d  = mem_read_data;
                we_d    = 1'b1;
            end
            S_WRITE: begin
                src_d   = src_q + ADDR_WIDTH'(1);
                dst_d   = dst_q + ADDR_WIDTH'(1);
                count_d = count_q - ADDR_WIDTH'(1);
                if (count_q > ADDR_WIDTH'(1)) begin
                    state_d = S_READ;
                    busy_d  = 1'b1;
                    addr_d  = src_q + ADDR_WIDTH'(1);
                end else begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end
            end
            // data_q carries the fill pattern for the whole fill run.
            S_FILL: begin
                dst_d   = dst_q + ADDR_WIDTH'(1);
                count_d = count_q - ADDR_WIDTH'(1);
                if (count_q > ADDR_WIDTH'(1)) begin
                    busy_d = 1'b1;
                    addr_d = dst_q + ADDR_WIDTH'(1);
                    data_d = data_q;
                    we_d   = 1'b1;
                end else begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (abort) begin
            state_d = S_IDLE;
            src_d   = src_q;
            dst_d   = dst_q;
            count_d = count_q;
            data_d  = '0;
            addr_d  = '0;
            we_d    = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            count_q <= '0;
            data_q  <= '0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            count_q <= count_d;
            data_q  <= data_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy             = busy_q;
    assign done             = done_q;
    assign mem_address      = addr_q;
    assign mem_write_data   = data_q;
    assign mem_write_enable = we_q;

endmodule

// File: tb/tb_memory_copy_engine.sv
// tb/tb_memory_copy_engine.sv - self-checking bench for memory_copy_engine
module tb_memory_copy_engine;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        start;
    logic        fill_mode;
    logic [15:0] src_addr;
    logic [15:0] dst_addr;
    logic [15:0] length;
    logic [15:0] fill_value;
    logic        abort;
    logic        busy;
    logic        done;
    logic [15:0] mem_address;
    logic [15:0] mem_write_data;
    logic        mem_write_enable;
    logic [15:0] mem_read_data;

    memory_copy_engine #(.ADDR_WIDTH(16), .DATA_WIDTH(16)) dut (
        .clock            (clock),
        .reset_n          (reset_n),
        .start            (start),
        .fill_mode        (fill_mode),
        .src_addr         (src_addr),
        .dst_addr         (dst_addr),
        .length           (length),
        .fill_value       (fill_value),
        .abort            (abort),
        .busy             (busy),
        .done             (done),
        .mem_address      (mem_address),
        .mem_write_data   (mem_write_data),
        .mem_write_enable (mem_write_enable),
        .mem_read_data    (mem_read_data)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] d;
    } wr_t;

    typedef struct {
        logic        fill;
        logic [15:0] src;
        logic [15:0] dst;
        logic [15:0] len;
        logic [15:0] fval;
        int          exp_done;
        int          abort_k;
        int          poke_k;
    } tv_t;

    logic [15:0] mem     [0:65535];
    logic [15:0] ref_mem [0:65535];
    wr_t         exp_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    tv_t         tv[7];

    function automatic logic [15:0] init_val(input logic [15:0] a);
        if (a == 16'h0100) return 16'hAAAA;
        if (a == 16'h0101) return 16'hBBBB;
        if (a == 16'h0102) return 16'hCCCC;
        if (a == 16'h0010) return 16'h5555;
        if (a >= 16'h0500 && a <= 16'h0507) return {12'h500, a[3:0]};
        if (a >= 16'h0600 && a <= 16'h0607) return 16'hDEAD;
        if (a == 16'hFFFF) return 16'h7777;
        return 16'h0000;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Memory model: samples on negedge, read data ready before the next posedge.
    initial begin
        wr_t w;
        for (int i = 0; i < 65536; i++) mem[i] = init_val(16'(i));
        mem_read_data = '0;
        forever begin
            @(negedge clock);
            if (mem_write_enable === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_write actual=%h:%h required=none", mem_address, mem_write_data);
                end else begin
                    w = exp_q.pop_front();
                    check("write_addr", 32'(mem_address), 32'(w.a));
                    check("write_data", 32'(mem_write_data), 32'(w.d));
                end
                mem[mem_address] = mem_write_data;
            end
            mem_read_data = mem[mem_address];
        end
    end

    task automatic run(input tv_t v);
        int          nw;
        int          done_at;
        int          errs;
        logic        exp_we;
        logic [15:0] s;
        logic [15:0] d;
        logic [15:0] val;
        nw = int'(v.len);
        if (v.abort_k >= 0) begin
            if (v.fill) nw = (v.abort_k + 1 < nw) ? v.abort_k + 1 : nw;
            else        nw = ((v.abort_k + 1) / 2 < nw) ? (v.abort_k + 1) / 2 : nw;
        end
        s = v.src;
        d = v.dst;
        for (int i = 0; i < nw; i++) begin
            val = v.fill ? v.fval : ref_mem[s];
            ref_mem[d] = val;
            exp_q.push_back({d, val});
            s = s + 16'd1;
            d = d + 16'd1;
        end
        @(negedge clock);
        fill_mode  = v.fill;
        src_addr   = v.src;
        dst_addr   = v.dst;
        length     = v.len;
        fill_value = v.fval;
        start      = 1'b1;
        @(posedge clock);
        #1;
        start   = 1'b0;
        done_at = -1;
        errs    = 0;
        for (int k = 0; k < 600; k++) begin
            if (v.abort_k >= 0 && k == v.abort_k) abort = 1'b1;
            if (v.abort_k >= 0 && k == v.abort_k + 1) begin
                abort = 1'b0;
                check("abort_busy_fall", 32'(busy), 32'd0);
            end
            if (k == v.poke_k) begin
                start      = 1'b1;
                fill_mode  = 1'b1;
                dst_addr   = 16'h3000;
                length     = 16'd2;
                fill_value = 16'h9999;
            end
            if (k == v.poke_k + 1) start = 1'b0;
            if (done === 1'b1) begin
                done_at = k;
                break;
            end
            if (v.abort_k < 0 || k <= v.abort_k) begin
                exp_we = v.fill ? 1'b1 : k[0];
                if (busy !== 1'b1) errs++;
                if (mem_write_enable !== exp_we) errs++;
            end
            if (v.abort_k >= 0 && k >= v.abort_k + 8) break;
            @(posedge clock);
            #1;
        end
        check("done_cycle", 32'(done_at), 32'(v.exp_done));
        check("busy_we_pattern_errs", 32'(errs), 32'd0);
        if (done_at >= 0) begin
            check("busy_at_done", 32'(busy), 32'd0);
            check("we_at_done", 32'(mem_write_enable), 32'd0);
        end
        @(posedge clock);
        #1;
        check("writes_outstanding", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        int errs;
        reset_n    = 1'b0;
        start      = 1'b0;
        fill_mode  = 1'b0;
        src_addr   = '0;
        dst_addr   = '0;
        length     = '0;
        fill_value = '0;
        abort      = 1'b0;
        for (int i = 0; i < 65536; i++) ref_mem[i] = init_val(16'(i));

        //       fill  src       dst       len    fval      done abort poke
        tv[0] = '{1'b0, 16'h0100, 16'h0200, 16'd3, 16'h0000,  6, -1, -1};
        tv[1] = '{1'b1, 16'h0000, 16'hFFFE, 16'd4, 16'h1234,  4, -1, -1};
        tv[2] = '{1'b0, 16'h0300, 16'h0400, 16'd0, 16'h0000,  0, -1, -1};
        tv[3] = '{1'b0, 16'h0010, 16'h0011, 16'd4, 16'h0000,  8, -1,  3};
        tv[4] = '{1'b0, 16'h0500, 16'h0600, 16'd8, 16'h0000, -1,  4, -1};
        tv[5] = '{1'b1, 16'h0000, 16'h0700, 16'd1, 16'hBEEF,  1, -1, -1};
        tv[6] = '{1'b0, 16'hFFFF, 16'h0800, 16'd2, 16'h0000,  4, -1, -1};

        repeat (3) @(posedge clock);
        #1;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_addr", 32'(mem_address), 32'd0);
        check("reset_wdata", 32'(mem_write_data), 32'd0);
        check("reset_we", 32'(mem_write_enable), 32'd0);
        @(negedge clock);
        reset_n = 1'b1;

        for (int i = 0; i < 7; i++) run(tv[i]);

        check("copy_dst0", 32'(mem[16'h0200]), 32'h0000AAAA);
        check("copy_dst1", 32'(mem[16'h0201]), 32'h0000BBBB);
        check("copy_dst2", 32'(mem[16'h0202]), 32'h0000CCCC);
        check("fill_fffe", 32'(mem[16'hFFFE]), 32'h00001234);
        check("fill_ffff", 32'(mem[16'hFFFF]), 32'h00001234);
        check("fill_0000", 32'(mem[16'h0000]), 32'h00001234);
        check("fill_0001", 32'(mem[16'h0001]), 32'h00001234);
        for (int i = 0; i < 4; i++) check("smear", 32'(mem[16'h0011 + 16'(i)]), 32'h00005555);
        check("ignored_start_target", 32'(mem[16'h3000]), 32'd0);
        check("abort_dst0", 32'(mem[16'h0600]), 32'h00005000);
        check("abort_dst1", 32'(mem[16'h0601]), 32'h00005001);
        check("abort_dst2_unchanged", 32'(mem[16'h0602]), 32'h0000DEAD);
        check("fill_single", 32'(mem[16'h0700]), 32'h0000BEEF);
        check("wrap_src_copy", 32'(mem[16'h0801]), 32'h00001234);

        // start and abort together in IDLE: the start is dropped
        @(negedge clock);
        start      = 1'b1;
        abort      = 1'b1;
        fill_mode  = 1'b1;
        dst_addr   = 16'h3100;
        length     = 16'd2;
        fill_value = 16'h4444;
        @(posedge clock);
        #1;
        start = 1'b0;
        abort = 1'b0;
        errs  = 0;
        for (int k = 0; k < 4; k++) begin
            if (busy !== 1'b0 || done !== 1'b0) errs++;
            @(posedge clock);
            #1;
        end
        check("start_abort_idle", 32'(errs), 32'd0);

        // asynchronous reset in the middle of a fill
        for (int i = 0; i < 3; i++) exp_q.push_back({16'h4000 + 16'(i), 16'hA5A5});
        @(negedge clock);
        fill_mode  = 1'b1;
        dst_addr   = 16'h4000;
        length     = 16'd20;
        fill_value = 16'hA5A5;
        start      = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        repeat (3) begin
            @(posedge clock);
            #1;
        end
        check("fill_we_before_reset", 32'(mem_write_enable), 32'd1);
        #1;
        reset_n = 1'b0;
        #1;
        check("async_we", 32'(mem_write_enable), 32'd0);
        check("async_busy", 32'(busy), 32'd0);
        check("async_addr", 32'(mem_address), 32'd0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        errs = 0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clock);
            #1;
            if (busy !== 1'b0 || done !== 1'b0 || mem_write_enable !== 1'b0) errs++;
        end
        check("idle_after_reset", 32'(errs), 32'd0);
        check("reset_writes_outstanding", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
